// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the sequential multiply-accumulate block.
package mac_pkg;

    localparam int OP_W  = 16;                // operand width
    localparam int RES_W = 32;                // product / accumulator width
    localparam int ITER  = 16;                // shift-add iterations per multiply
    localparam int CNT_W = $clog2(ITER);      // iteration counter width

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ITER - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ACC,
        DONE
    } state_e;

endpackage

// File: rtl/thirty_two_bit_adder.sv
// 32-bit ripple-carry adder built from a chain of full-adder bit slices.
module thirty_two_bit_adder (
    input  logic [31:0] x_i,
    input  logic [31:0] y_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [32:0] carry;

    assign carry[0] = cin_i;

    // One full adder per bit; the carry ripples from bit 0 upward.
    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum_o[i]     = x_i[i] ^ y_i[i] ^ carry[i];
        assign carry[i + 1] = (x_i[i] & y_i[i]) | (carry[i] & (x_i[i] ^ y_i[i]));
    end

    assign cout_o = carry[32];

endmodule

// File: rtl/seq_mac_ctrl.sv
// Sequential shift-add multiplier with an optional accumulate step.
// One shared adder serves both the partial-product sums (CALC) and the
// accumulator update (ACC); its operands are selected by the current state.
module seq_mac_ctrl
    import mac_pkg::*;
#(
    parameter int OP_W = mac_pkg::OP_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic             acc_en,
    input  logic             clr_acc,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] product,
    output logic [RES_W-1:0] acc,
    output logic             overflow
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RES_W-1:0]   mcand_q;      // multiplicand, shifted left each iteration
    logic [OP_W-1:0]    mplier_q;     // multiplier, shifted right each iteration
    logic               acc_en_q;
    logic [RES_W-1:0]   product_q;
    logic [RES_W-1:0]   acc_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;

    logic [RES_W-1:0]   add_x;
    logic [RES_W-1:0]   add_y;
    logic [RES_W-1:0]   add_sum;
    logic               add_cout;

    // Select the shared adder operands according to the current state.
    always_comb begin
        // NOTE: defaults first so every path assigns both operands and no latch is inferred.
        add_x = '0;
        add_y = '0;
        case (state_q)
            CALC: begin
                add_x = product_q;
                add_y = mcand_q;
            end
            ACC: begin
                add_x = acc_q;
                add_y = product_q;
            end
            default: ;
        endcase
    end

    thirty_two_bit_adder u_adder (
        .x_i    (add_x),
        .y_i    (add_y),
        .cin_i  (1'b0),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Control FSM together with the datapath registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: every register here is plain flops (no memory arrays), so all are reset.
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_en_q  <= 1'b0;
            product_q <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (clr_acc) begin
                        acc_q <= '0;
                        ovf_q <= 1'b0;
                    end
                    if (start) begin
                        mcand_q   <= RES_W'(a);
                        mplier_q  <= b;
                        acc_en_q  <= acc_en;
                        product_q <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    if (mplier_q[0]) begin
                        product_q <= add_sum;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= acc_en_q ? ACC : DONE;
                        done_q  <= ~acc_en_q;
                    end
                end
                ACC: begin
                    acc_q <= add_sum;
                    if (add_cout) begin
                        ovf_q <= 1'b1;
                    end
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign product  = product_q;
    assign acc      = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_mac_ctrl.sv
// Directed self-checking bench for seq_mac_ctrl.
module tb_seq_mac_ctrl;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        acc_en;
    logic        clr_acc;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic [31:0] acc;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    seq_mac_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a        (a),
        .b        (b),
        .acc_en   (acc_en),
        .clr_acc  (clr_acc),
        .busy     (busy),
        .done     (done),
        .product  (product),
        .acc      (acc),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a start request on a falling edge; returns just after the accepting rising edge.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic ten, input logic tclr);
        @(negedge clk);
        a       = ta;
        b       = tb_;
        acc_en  = ten;
        clr_acc = tclr;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        clr_acc = 1'b0;
    endtask

    // Count rising edges after acceptance until done is seen (sampled on falling edges).
    // With inject set, start (and clr_acc on the first) is pulsed into edges 5 and 10.
    task automatic wait_done(input string tag, input bit inject, output int lat);
        lat = TIMEOUT + 1;
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (inject) begin
                start   = (k == 5) || (k == 10);
                clr_acc = (k == 5);
                a       = 16'h0001;
                b       = 16'h0001;
            end
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
        start   = 1'b0;
        clr_acc = 1'b0;
        if (lat <= TIMEOUT) begin
            // done must drop after one cycle and the block must return to idle
            @(negedge clk);
            check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
            check({tag, "_idle"}, {31'b0, busy}, 32'd0);
        end
    endtask

    // Hard stop if anything hangs beyond every bounded wait.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int extra;

        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        acc_en  = 1'b0;
        clr_acc = 1'b0;

        // Reset state
        #12;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_acc", acc, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 3*5, no accumulate: done after 16 edges, acc untouched
        issue(16'd3, 16'd5, 1'b0, 1'b0);
        check("mul3x5_busy", {31'b0, busy}, 32'd1);
        wait_done("mul3x5", 1'b0, lat);
        check("mul3x5_lat", 32'(lat), 32'd16);
        check("mul3x5_product", product, 32'h0000_000F);
        check("mul3x5_acc", acc, 32'd0);

        // Max operands with accumulate, cleared first: done after 17 edges
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        wait_done("max_clr", 1'b0, lat);
        check("max_clr_lat", 32'(lat), 32'd17);
        check("max_clr_product", product, 32'hFFFE_0001);
        check("max_clr_acc", acc, 32'hFFFE_0001);
        check("max_clr_ovf", {31'b0, overflow}, 32'd0);

        // Same again without clearing: accumulator wraps and overflow sets
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        wait_done("max_wrap", 1'b0, lat);
        check("max_wrap_lat", 32'(lat), 32'd17);
        check("max_wrap_acc", acc, 32'hFFFC_0002);
        check("max_wrap_ovf", {31'b0, overflow}, 32'd1);

        // Standalone clear in idle
        @(negedge clk);
        clr_acc = 1'b1;
        @(posedge clk);
        #1;
        clr_acc = 1'b0;
        check("clr_acc_val", acc, 32'd0);
        check("clr_ovf_val", {31'b0, overflow}, 32'd0);
        check("clr_busy", {31'b0, busy}, 32'd0);

        // Build acc = 0x100 (16*16 accumulated from zero)
        issue(16'd16, 16'd16, 1'b1, 1'b0);
        wait_done("acc100", 1'b0, lat);
        check("acc100_acc", acc, 32'h0000_0100);

        // 7*9 with start and clr_acc poked while busy: both ignored
        issue(16'd7, 16'd9, 1'b0, 1'b0);
        wait_done("busy_start", 1'b1, lat);
        check("busy_start_lat", 32'(lat), 32'd16);
        check("busy_start_product", product, 32'h0000_003F);
        check("busy_clr_acc", acc, 32'h0000_0100);
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check("busy_start_extra_done", 32'(extra), 32'd0);
        check("busy_start_no_restart", {31'b0, busy}, 32'd0);

        // clr_acc and start in the same idle cycle: accumulation restarts from 0
        issue(16'd4, 16'd4, 1'b1, 1'b1);
        wait_done("clr_start", 1'b0, lat);
        check("clr_start_lat", 32'(lat), 32'd17);
        check("clr_start_product", product, 32'h0000_0010);
        check("clr_start_acc", acc, 32'h0000_0010);
        check("clr_start_ovf", {31'b0, overflow}, 32'd0);

        // Reset mid-CALC aborts immediately, then a fresh multiply behaves normally
        issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        repeat (8) @(negedge clk);
        check("midcalc_busy_pre", {31'b0, busy}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_product", product, 32'd0);
        check("midrst_acc", acc, 32'd0);
        check("midrst_ovf", {31'b0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        issue(16'd2, 16'd0, 1'b0, 1'b0);
        wait_done("post_rst", 1'b0, lat);
        check("post_rst_lat", 32'(lat), 32'd16);
        check("post_rst_product", product, 32'd0);
        check("post_rst_acc", acc, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
